// File: rtl/btn_event_encoder_if.sv
// Event stream handshake between btn_event_encoder and its consumer.
// The producer drives a show-ahead head entry (row/col/release) with ev_valid;
// the consumer pops it by asserting ev_ready while ev_valid is high.
//   master : producer side (drives ev_valid, ev_row, ev_col, ev_release)
//   slave  : consumer side (drives ev_ready)
interface btn_event_encoder_if #(
   parameter int unsigned RW = 3,
   parameter int unsigned CW = 3
);
   logic          ev_valid;
   logic          ev_ready;
   logic [RW-1:0] ev_row;
   logic [CW-1:0] ev_col;
   logic          ev_release;

   modport master (output ev_valid, ev_row, ev_col, ev_release, input ev_ready);
   modport slave  (input ev_valid, ev_row, ev_col, ev_release, output ev_ready);
endinterface

// File: rtl/btn_event_encoder.sv
// Button array event encoder.
// Synchronises and debounces a ROWS x COLS array of raw button levels, reports
// the lowest-index held button as a registered row/col, and queues every
// debounced press edge as a (row, col) event in a show-ahead FIFO.
// Optional macro BTN_RELEASE_EVT_EN: release edges are queued too, with
// ev_release=1; when undefined, releases are ignored and ev_release is 0.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   btn[N]           raw button levels, btn[i] is row i/COLS, col i%COLS
//   held_any/row/col registered lowest-index held button (0 when none)
//   ev (master)      event stream: ev_valid/ev_ready/ev_row/ev_col/ev_release
//   ev_overflow      sticky flag, set when an edge was merged into a pending one
//   ovf_clr          clears ev_overflow (a same-cycle set wins)
module btn_event_encoder #(
   parameter int unsigned ROWS     = 5,
   parameter int unsigned COLS     = 5,
   parameter int unsigned DB_TICKS = 100000,
   parameter int unsigned DB_COUNT = 4,
   parameter int unsigned DEPTH    = 8,
   localparam int unsigned N  = ROWS * COLS,
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        btn,
   output logic                held_any,
   output logic [RW-1:0]       held_row,
   output logic [CW-1:0]       held_col,
   btn_event_encoder_if.master ev,
   output logic                ev_overflow,
   input  logic                ovf_clr
);

   localparam int unsigned PW      = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [3:0]  DbCount = 4'(DB_COUNT);
`ifdef BTN_RELEASE_EVT_EN
   // Request k is button k/2; odd k is its release, so press wins for equal index.
   localparam int unsigned NR = 2 * N;
`else
   localparam int unsigned NR = N;
`endif

   logic [N-1:0]     s1, s2, deb, deb_d, rise, pend, gnt_press;
   logic [3:0]       cnt [N];
   logic [PW-1:0]    presc;
   logic             tick;
   logic [NR-1:0]    req, gnt;
   logic             sel_found;
   logic [RW-1:0]    sel_row, held_row_d;
   logic [CW-1:0]    sel_col, held_col_d;
   logic             push, pop, full, ovf_set;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [RW+CW-1:0] mem [DEPTH];
`ifdef BTN_RELEASE_EVT_EN
   logic [N-1:0]     fall, pend_rel, gnt_rel;
   logic             sel_rel;
   logic [DEPTH-1:0] mem_rel;
`endif

   assign tick = (presc == PW'(DB_TICKS - 1));

   // Synchroniser, prescaler and per-button debounce counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= '0;
         s2    <= '0;
         deb   <= '0;
         deb_d <= '0;
         presc <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         deb_d <= deb;
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            for (int i = 0; i < N; i++) begin
               if (s2[i] != deb[i]) begin
                  if (cnt[i] + 4'd1 == DbCount) begin
                     deb[i] <= s2[i];
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 4'd1;
                  end
               end else begin
                  cnt[i] <= '0;
               end
            end
         end
      end
   end

   assign rise = deb & ~deb_d;
`ifdef BTN_RELEASE_EVT_EN
   assign fall = ~deb & deb_d;
`endif

   always_comb begin
      req = '0;
`ifdef BTN_RELEASE_EVT_EN
      for (int i = 0; i < N; i++) begin
         req[2*i]   = pend[i];
         req[2*i+1] = pend_rel[i];
      end
`else
      req = pend;
`endif
   end

   // Fixed-priority arbiter: lowest request index wins the single push slot.
   always_comb begin
      sel_found = 1'b0;
      sel_row   = '0;
      sel_col   = '0;
      gnt       = '0;
`ifdef BTN_RELEASE_EVT_EN
      sel_rel   = 1'b0;
`endif
      for (int k = 0; k < NR; k++) begin
         if (!sel_found && req[k]) begin
            sel_found = 1'b1;
            gnt[k]    = 1'b1;
`ifdef BTN_RELEASE_EVT_EN
            sel_row   = RW'((k / 2) / COLS);
            sel_col   = CW'((k / 2) % COLS);
            sel_rel   = k[0];
`else
            sel_row   = RW'(k / COLS);
            sel_col   = CW'(k % COLS);
`endif
         end
      end
   end

`ifdef BTN_RELEASE_EVT_EN
   always_comb begin
      gnt_press = '0;
      gnt_rel   = '0;
      for (int i = 0; i < N; i++) begin
         gnt_press[i] = gnt[2*i];
         gnt_rel[i]   = gnt[2*i+1];
      end
   end
`else
   assign gnt_press = gnt;
`endif

   assign full = (count == (AW+1)'(DEPTH));
   assign pop  = ev.ev_valid & ev.ev_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push = sel_found & (~full | pop);

   // Only an edge that cannot be kept separately is counted as lost.
`ifdef BTN_RELEASE_EVT_EN
   assign ovf_set = |(rise & pend & ~(gnt_press & {N{push}})) |
                    |(fall & pend_rel & ~(gnt_rel & {N{push}}));
`else
   assign ovf_set = |(rise & pend & ~(gnt_press & {N{push}}));
`endif

   // Lowest-index held button; scanning downward lets the lowest index win.
   always_comb begin
      held_row_d = '0;
      held_col_d = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (deb[i]) begin
            held_row_d = RW'(i / COLS);
            held_col_d = CW'(i % COLS);
         end
      end
   end

   // Pending edges, sticky overflow and held outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend        <= '0;
`ifdef BTN_RELEASE_EVT_EN
         pend_rel    <= '0;
`endif
         ev_overflow <= 1'b0;
         held_any    <= 1'b0;
         held_row    <= '0;
         held_col    <= '0;
      end else begin
         pend <= (pend & ~(gnt_press & {N{push}})) | rise;
`ifdef BTN_RELEASE_EVT_EN
         pend_rel <= (pend_rel & ~(gnt_rel & {N{push}})) | fall;
`endif
         if (ovf_set) begin
            ev_overflow <= 1'b1;
         end else if (ovf_clr) begin
            ev_overflow <= 1'b0;
         end
         held_any <= |deb;
         held_row <= held_row_d;
         held_col <= held_col_d;
      end
   end

   // Event FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef BTN_RELEASE_EVT_EN
         mem_rel <= '0;
`endif
      end else begin
         if (push) begin
            mem[wr_ptr] <= {sel_row, sel_col};
`ifdef BTN_RELEASE_EVT_EN
            mem_rel[wr_ptr] <= sel_rel;
`endif
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (!push && pop) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

   assign ev.ev_valid   = (count != '0);
   assign ev.ev_row     = mem[rd_ptr][RW+CW-1:CW];
   assign ev.ev_col     = mem[rd_ptr][CW-1:0];
`ifdef BTN_RELEASE_EVT_EN
   assign ev.ev_release = mem_rel[rd_ptr];
`else
   assign ev.ev_release = 1'b0;
`endif

endmodule

// File: doc/btn_event_encoder.md
Name: btn_event_encoder

Overview:
Parametrised successor to the flat button priority encoder. Samples a ROWS x COLS array of raw button levels, synchronises and debounces each one, and reports the held button as a registered priority-encoded row/col. Queues every debounced press edge as a (row, col) event in a small FIFO with a valid/ready handshake. Sits between board button pins and the demo controller/UART reporter.

Parameters:
ROWS, 5, button rows; ROWS >= 1
COLS, 5, button columns; COLS >= 1
DB_TICKS, 100000, clk cycles per debounce tick; >= 1
DB_COUNT, 4, consecutive disagreeing ticks needed to flip a debounced level; 1..15
DEPTH, 8, event FIFO entries; power of 2, >= 2
Derived: N = ROWS*COLS; RW = max(1,$clog2(ROWS)); CW = max(1,$clog2(COLS))

Ports:
clk  in  1  system clock
rst_n  in  1  reset
btn  in  N  raw asynchronous button levels, 1 = pressed; btn[i] maps to row i/COLS, col i%COLS
held_any  out  1  any debounced button held
held_row  out  RW  row of lowest-index held button, 0 if none
held_col  out  CW  col of lowest-index held button, 0 if none
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_row  out  RW  head event row
ev_col  out  CW  head event col
ev_release  out  1  head event is a release (see Optional Feature)
ev_overflow  out  1  sticky: an edge was lost
ovf_clr  in  1  clears ev_overflow

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All state clears on rst_n=0: sync flops, debounced levels, counters, pending flags, FIFO; all outputs 0. Reset mid-operation discards queued events and pending edges.
- Sync: each btn bit passes 2 flops (s2).
- Tick: prescaler 0..DB_TICKS-1; tick=1 in the cycle prescaler==DB_TICKS-1 (DB_TICKS=1: every cycle).
- Debounce per button: 4-bit counter. On tick: if s2 != deb, cnt+1; when cnt+1 == DB_COUNT, deb <= s2 and cnt <= 0. If s2 == deb on a tick, cnt <= 0. No change on non-tick cycles.
- Edge: rise = deb & ~deb_d (deb_d = deb delayed 1 cycle). A rise sets pend[i]. Rise while pend[i] already set -> ev_overflow <= 1, edge merged.
- Held outputs: registered; lowest set index of deb_d -> held_row/col, held_any = |deb_d. 1 cycle after deb change.
- Push: each cycle, lowest-index set pend[i] is pushed if FIFO not full or a pop occurs same cycle; pend[i] cleared in that cycle. At most one push per cycle. Full with no pop: pend held, nothing lost.
- FIFO: show-ahead; ev_valid = count != 0; pop when ev_valid & ev_ready; push-only, pop-only, push+pop (count unchanged, incl. full) all legal. Push to empty FIFO: ev_valid in next cycle.
- Latency with DB_TICKS=1: btn rise at cycle 0 -> s2 at cycle 2 -> deb at cycle 2+DB_COUNT -> pend next -> ev_valid 2 cycles after deb.
- ev_overflow: set-priority over ovf_clr in same cycle.
- ev_ready while ev_valid=0: ignored.

Optional Feature:
BTN_RELEASE_EVT_EN. Defined: falls (~deb & deb_d) set a separate pend_rel[i]; release events queued with ev_release=1; arbitration lowest index, press before release for the same index; re-fall while pend_rel set -> ev_overflow. Not defined: falls ignored, ev_release tied 0, no pend_rel storage.

Test Plan:
Reset: rst_n=0 mid-traffic with 3 queued events -> all outputs 0, ev_valid=0 after release, no stale event.
Debounce (DB_TICKS=1, DB_COUNT=4): btn[7] toggles every 2 cycles for 20 cycles then held 1 -> exactly one event row=1 col=2; held_row=1, held_col=2.
Simultaneous: btn[3] and btn[20] rise same cycle, ev_ready=1 -> events (0,3) then (4,0) in consecutive cycles.
Full: DEPTH=4, ev_ready=0, press 6 distinct buttons -> 4 queued, 2 pending, ev_overflow=0; then ev_ready=1 -> all 6 drained in index order.
Overflow: ev_ready=0, FIFO full, press/release/press btn[0] twice -> ev_overflow=1; ovf_clr -> 0.
Macro on: press then release btn[24] -> events (4,4,rel=0) then (4,4,rel=1); macro off -> only (4,4,rel=0).
